// File: rtl/dmem_pkg.sv
// Shared types and constants for the two-master data-RAM arbiter.
// Holds the FSM state enum, master id type, RAM geometry and the address check.
package dmem_pkg;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic master_id_t;
  localparam master_id_t M_CPU = 1'b0;
  localparam master_id_t M_DBG = 1'b1;

  // Word aligned and inside the RAM's byte range.
  function automatic logic addr_ok(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr < 32'(DEPTH * 4));
  endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// Grant logic for the two-master data-RAM arbiter.
// DMEM_ARB_RR_EN defined: round-robin with a priority pointer that flips to the
// non-winner on every grant. Undefined: fixed priority, m0 always wins.
module dmem_arb_grant
  import dmem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_m0_valid,
  input  logic i_m1_valid,
  input  logic i_arb_en,
  output logic o_grant0,
  output logic o_grant1
);

`ifdef DMEM_ARB_RR_EN
  master_id_t r_prio;

  // Grant the preferred master if it asks, otherwise the other one.
  always_comb begin
    o_grant0 = 1'b0;
    o_grant1 = 1'b0;
    if (i_arb_en) begin
      if (r_prio == M_CPU) begin
        o_grant0 = i_m0_valid;
        o_grant1 = i_m1_valid && !i_m0_valid;
      end else begin
        o_grant1 = i_m1_valid;
        o_grant0 = i_m0_valid && !i_m1_valid;
      end
    end
  end

  // Pointer moves to the master that lost (or did not ask) on each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= M_CPU;
    end else if (o_grant0) begin
      r_prio <= M_DBG;
    end else if (o_grant1) begin
      r_prio <= M_CPU;
    end
  end
`else
  // Fixed priority needs no state; clk/rst_n are kept for a uniform port list.
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst_n};

  // CPU always wins; debug port only when the CPU is silent.
  always_comb begin
    o_grant0 = i_arb_en && i_m0_valid;
    o_grant1 = i_arb_en && i_m1_valid && !i_m0_valid;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for the single-port 32x32 data RAM.
// IDLE accepts one request, ACCESS drives one RAM cycle, RESP returns the result.
// Optional macro DMEM_ARB_RR_EN selects round-robin instead of fixed m0 priority.
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic        m0_req_write,
  input  logic [31:0] m0_req_addr,
  input  logic [31:0] m0_req_wdata,
  output logic        m0_rsp_valid,
  output logic [31:0] m0_rsp_rdata,
  output logic        m0_rsp_err,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic        m1_req_write,
  input  logic [31:0] m1_req_addr,
  input  logic [31:0] m1_req_wdata,
  output logic        m1_rsp_valid,
  output logic [31:0] m1_rsp_rdata,
  output logic        m1_rsp_err,
  output logic [31:0] ram_address,
  output logic [31:0] ram_writedata,
  output logic        ram_write_en,
  output logic        ram_read_en,
  input  logic [31:0] ram_readdata
);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_write;
  master_id_t  r_owner;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        w_arb_en;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_addr_ok;

  // Ready is gated by rst_n so every output reads 0 while reset is held.
  assign w_arb_en  = (r_state == IDLE) && rst_n;
  assign w_addr_ok = addr_ok(r_addr);

  dmem_arb_grant u_grant (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_m0_valid (m0_req_valid),
    .i_m1_valid (m1_req_valid),
    .i_arb_en   (w_arb_en),
    .o_grant0   (w_grant0),
    .o_grant1   (w_grant1)
  );

  assign m0_req_ready = w_grant0;
  assign m1_req_ready = w_grant1;

  // Next-state: IDLE waits for a grant, then ACCESS and RESP take one cycle each.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_grant0 || w_grant1) w_state_next = ACCESS;
      ACCESS:  w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Latch the winning request in IDLE; capture result at the end of ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_owner <= M_CPU;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_grant1) begin
        r_addr  <= m1_req_addr;
        r_wdata <= m1_req_wdata;
        r_write <= m1_req_write;
        r_owner <= M_DBG;
      end else if (w_grant0) begin
        r_addr  <= m0_req_addr;
        r_wdata <= m0_req_wdata;
        r_write <= m0_req_write;
        r_owner <= M_CPU;
      end
      if (r_state == ACCESS) begin
        r_err   <= !w_addr_ok;
        r_rdata <= (w_addr_ok && !r_write) ? ram_readdata : 32'd0;
      end
    end
  end

  // RAM port is driven only during ACCESS of a legal address; zero otherwise.
  always_comb begin
    ram_address   = '0;
    ram_writedata = '0;
    ram_write_en  = 1'b0;
    ram_read_en   = 1'b0;
    if ((r_state == ACCESS) && w_addr_ok) begin
      ram_address   = {{(32 - AW){1'b0}}, r_addr[AW+1:2]};
      ram_writedata = r_wdata;
      ram_write_en  = r_write;
      ram_read_en   = !r_write;
    end
  end

  // Response goes only to the owner of the latched request, during RESP.
  always_comb begin
    m0_rsp_valid = 1'b0;
    m0_rsp_rdata = '0;
    m0_rsp_err   = 1'b0;
    m1_rsp_valid = 1'b0;
    m1_rsp_rdata = '0;
    m1_rsp_err   = 1'b0;
    if (r_state == RESP) begin
      if (r_owner == M_CPU) begin
        m0_rsp_valid = 1'b1;
        m0_rsp_rdata = r_rdata;
        m0_rsp_err   = r_err;
      end else begin
        m1_rsp_valid = 1'b1;
        m1_rsp_rdata = r_rdata;
        m1_rsp_err   = r_err;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 32x32 RAM.
// Honours DMEM_ARB_RR_EN for the contention expectations.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req_valid, m0_req_ready, m0_req_write;
  logic [31:0] m0_req_addr, m0_req_wdata;
  logic        m0_rsp_valid, m0_rsp_err;
  logic [31:0] m0_rsp_rdata;
  logic        m1_req_valid, m1_req_ready, m1_req_write;
  logic [31:0] m1_req_addr, m1_req_wdata;
  logic        m1_rsp_valid, m1_rsp_err;
  logic [31:0] m1_rsp_rdata;
  logic [31:0] ram_address, ram_writedata, ram_readdata;
  logic        ram_write_en, ram_read_en;

  logic [31:0] mem [32];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m0_req_valid  (m0_req_valid),
    .m0_req_ready  (m0_req_ready),
    .m0_req_write  (m0_req_write),
    .m0_req_addr   (m0_req_addr),
    .m0_req_wdata  (m0_req_wdata),
    .m0_rsp_valid  (m0_rsp_valid),
    .m0_rsp_rdata  (m0_rsp_rdata),
    .m0_rsp_err    (m0_rsp_err),
    .m1_req_valid  (m1_req_valid),
    .m1_req_ready  (m1_req_ready),
    .m1_req_write  (m1_req_write),
    .m1_req_addr   (m1_req_addr),
    .m1_req_wdata  (m1_req_wdata),
    .m1_rsp_valid  (m1_rsp_valid),
    .m1_rsp_rdata  (m1_rsp_rdata),
    .m1_rsp_err    (m1_rsp_err),
    .ram_address   (ram_address),
    .ram_writedata (ram_writedata),
    .ram_write_en  (ram_write_en),
    .ram_read_en   (ram_read_en),
    .ram_readdata  (ram_readdata)
  );

  // Behavioural RAM: combinational read, synchronous write.
  assign ram_readdata = mem[ram_address[4:0]];
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_address[4:0]] <= ram_writedata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic chk_ram_idle(input string tag);
    chk({tag, "_ram_addr"}, ram_address, 32'd0);
    chk({tag, "_ram_wdata"}, ram_writedata, 32'd0);
    chk({tag, "_ram_en"}, {30'd0, ram_write_en, ram_read_en}, 32'd0);
  endtask

  // One full transaction from IDLE; exp_en says whether the RAM must be touched.
  task automatic do_txn(input int m, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_en,
                        input logic [31:0] exp_word, input logic [31:0] exp_rdata,
                        input logic exp_err);
    if (m == 0) begin
      m0_req_valid = 1'b1; m0_req_write = wr; m0_req_addr = addr; m0_req_wdata = wdata;
    end else begin
      m1_req_valid = 1'b1; m1_req_write = wr; m1_req_addr = addr; m1_req_wdata = wdata;
    end
    #1;
    chk("idle_ready_m0", m0_req_ready, m == 0);
    chk("idle_ready_m1", m1_req_ready, m == 1);
    tick();
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
    chk("acc_ready", {m0_req_ready, m1_req_ready}, 32'd0);
    chk("acc_wen", ram_write_en, exp_en && wr);
    chk("acc_ren", ram_read_en, exp_en && !wr);
    chk("acc_addr", ram_address, exp_en ? exp_word : 32'd0);
    chk("acc_wdata", ram_writedata, (exp_en && wr) ? wdata : 32'd0);
    tick();
    chk("rsp_valid_owner", (m == 0) ? m0_rsp_valid : m1_rsp_valid, 32'd1);
    chk("rsp_valid_other", (m == 0) ? m1_rsp_valid : m0_rsp_valid, 32'd0);
    chk("rsp_rdata", (m == 0) ? m0_rsp_rdata : m1_rsp_rdata, exp_rdata);
    chk("rsp_err", (m == 0) ? m0_rsp_err : m1_rsp_err, exp_err);
    chk("rsp_rdata_other", (m == 0) ? m1_rsp_rdata : m0_rsp_rdata, 32'd0);
    chk("rsp_ready", {m0_req_ready, m1_req_ready}, 32'd0);
    chk_ram_idle("rsp");
    tick();
    chk("post_rsp_valid", {m0_rsp_valid, m1_rsp_valid}, 32'd0);
    $display("txn m%0d %s addr=0x%08h wdata=0x%08h exp_rdata=0x%08h exp_err=%0d",
             m, wr ? "store" : "load ", addr, wdata, exp_rdata, exp_err);
  endtask

  initial begin
    logic exp_g1;
    m0_req_valid = 1'b0; m0_req_write = 1'b0; m0_req_addr = '0; m0_req_wdata = '0;
    m1_req_valid = 1'b0; m1_req_write = 1'b0; m1_req_addr = '0; m1_req_wdata = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;

    // Reset state, with both masters requesting.
    m0_req_valid = 1'b1;
    m1_req_valid = 1'b1;
    #12;
    chk("rst_ready", {m0_req_ready, m1_req_ready}, 32'd0);
    chk("rst_rsp_valid", {m0_rsp_valid, m1_rsp_valid}, 32'd0);
    chk("rst_rsp_err", {m0_rsp_err, m1_rsp_err}, 32'd0);
    chk("rst_rsp_rdata", m0_rsp_rdata | m1_rsp_rdata, 32'd0);
    chk_ram_idle("rst");
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: m0 store then load word 5.
    do_txn(0, 1'b1, 32'h14, 32'hDEADBEEF, 1'b1, 32'd5, 32'd0, 1'b0);
    chk("t1_mem5", mem[5], 32'hDEADBEEF);
    do_txn(0, 1'b0, 32'h14, 32'd0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0);

    // 2: m1 load after reset with preloaded RAM.
    do_reset();
    mem[5] = 32'hAAAA0000;
    do_txn(1, 1'b0, 32'h14, 32'd0, 1'b1, 32'd5, 32'hAAAA0000, 1'b0);

    // 3: misaligned, out of range, and the last legal word.
    do_txn(0, 1'b0, 32'h06, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    do_txn(0, 1'b0, 32'h80, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    do_txn(0, 1'b1, 32'h80, 32'h55555555, 1'b0, 32'd0, 32'd0, 1'b1);
    mem[31] = 32'h12345678;
    do_txn(1, 1'b0, 32'h7C, 32'd0, 1'b1, 32'd31, 32'h12345678, 1'b0);

    // 4: continuous contention for four transactions.
    do_reset();
    mem[6] = 32'h66666666;
    m0_req_valid = 1'b1; m0_req_write = 1'b0; m0_req_addr = 32'h14;
    m1_req_valid = 1'b1; m1_req_write = 1'b0; m1_req_addr = 32'h18;
    #1;
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp_g1 = (i % 2) == 1;
`else
      exp_g1 = 1'b0;
`endif
      chk("t4_ready_m0", m0_req_ready, !exp_g1);
      chk("t4_ready_m1", m1_req_ready, exp_g1);
      tick();
      chk("t4_ram_addr", ram_address, exp_g1 ? 32'd6 : 32'd5);
      tick();
      chk("t4_rsp_m0", m0_rsp_valid, !exp_g1);
      chk("t4_rsp_m1", m1_rsp_valid, exp_g1);
      chk("t4_rdata", exp_g1 ? m1_rsp_rdata : m0_rsp_rdata,
          exp_g1 ? 32'h66666666 : 32'hAAAA0000);
      $display("txn contention %0d granted m%0d", i, exp_g1 ? 1 : 0);
      tick();
    end
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
    tick();

    // 5: reset during ACCESS of a load.
    m0_req_valid = 1'b1; m0_req_write = 1'b0; m0_req_addr = 32'h14;
    tick();
    m0_req_valid = 1'b0;
    chk("t5_ren_before", ram_read_en, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_ren_in_rst", ram_read_en, 32'd0);
    chk_ram_idle("t5");
    chk("t5_rsp_in_rst", {m0_rsp_valid, m1_rsp_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_rsp", {m0_rsp_valid, m1_rsp_valid}, 32'd0);
    end
    $display("txn m0 load aborted by reset");
    do_txn(0, 1'b0, 32'h14, 32'd0, 1'b1, 32'd5, 32'hAAAA0000, 1'b0);

    // 6: back-to-back m0 loads held valid.
    mem[6] = 32'h600D0006;
    m0_req_valid = 1'b1; m0_req_write = 1'b0; m0_req_addr = 32'h18;
    #1;
    for (int c = 0; c < 9; c++) begin
      chk("t6_ready", m0_req_ready, (c % 3) == 0);
      chk("t6_rsp_valid", m0_rsp_valid, (c % 3) == 2);
      if ((c % 3) == 2) begin
        chk("t6_rdata", m0_rsp_rdata, 32'h600D0006);
        $display("txn m0 back-to-back load %0d", c / 3);
      end
      tick();
    end
    m0_req_valid = 1'b0;
    tick();
    chk("t6_end_idle", {m0_rsp_valid, ram_read_en}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
